si_tag_gate: RTL and testbench
==============================

Name: si_tag_gate

Overview:
- Streaming filter between si_tag_converter and the measurement core; one tag per beat (TC_WORD_WIDTH = 1).
- Opens a time gate on a tag from a configurable start channel and closes it on a tag from a configurable stop channel.
- Forwards only tags that arrive while the gate is open.
- Wishbone slave for configuration, status and pass/drop counters.

Parameters:
- TS_WIDTH, 64, timestamp width in 1/3 ps units
- CH_WIDTH, 6, channel field width

Ports:
- sys_clk  in  1  single clock for all logic
- sys_clk_rst_n  in  1  reset, asynchronous, active-low
- s_tvalid  in  1  input tag valid
- s_tready  out  1  input tag ready
- s_timestamp  in  TS_WIDTH  input tag time
- s_channel  in  CH_WIDTH  input tag channel
- m_tvalid  out  1  output tag valid
- m_tready  in  1  output tag ready
- m_timestamp  out  TS_WIDTH  output tag time
- m_channel  out  CH_WIDTH  output tag channel
- wb_cyc, wb_stb, wb_we  in  1  Wishbone control
- wb_adr  in  8  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack  out  1  Wishbone acknowledge

Behaviour:
- Reset: m_tvalid=0, m_timestamp=0, m_channel=0, wb_ack=0, wb_dat_o=0. Gate state is CLOSED, ctrl=0, start_ch=0, stop_ch=1, timeout=0, all counters 0.
- Output register slice, 1-cycle latency:
  - s_tready = !m_tvalid || m_tready.
  - A tag is accepted when s_tvalid && s_tready.
  - m_* hold stable while m_tvalid && !m_tready.
- ctrl.enable=0 (bypass): every accepted tag is forwarded, state is forced to CLOSED, counters are frozen.
- ctrl.enable=1, FSM is evaluated once per accepted tag:
  - CLOSED, channel==start_ch: go to OPEN, open_ts<=timestamp, gates_cnt++. The tag itself is not forwarded and not counted.
  - CLOSED, any other tag: dropped, drop_cnt++.
  - OPEN, channel==stop_ch: go to CLOSED. The tag is not forwarded.
  - OPEN, channel==start_ch (and start_ch!=stop_ch): ignored; gate stays OPEN, open_ts is unchanged, tag is not forwarded.
  - OPEN, any other tag: forwarded, pass_cnt++.
- start_ch==stop_ch: the channel toggles the gate (CLOSED→OPEN, OPEN→CLOSED).
- Counters are 32-bit and saturate at 0xFFFFFFFF.
- ctrl.clear (write-1, self-clearing) zeroes all counters next cycle. If a count event occurs in the same cycle, clear wins.
- Writing enable 1→0 while OPEN forces CLOSED on the next cycle. A tag already in the output slice is still delivered.
- Wishbone:
  - wb_ack pulses one cycle after cyc&&stb, deasserts the following cycle.
  - Reads at unmapped addresses return 0; writes there are ignored.
- Register map (word addresses):
  - 0 ctrl (bit0 enable, bit1 clear)
  - 1 start_ch
  - 2 stop_ch
  - 3 timeout[31:0]
  - 4 timeout[63:32]
  - 5 pass_cnt (RO)
  - 6 drop_cnt (RO)
  - 7 gates_cnt (RO)
  - 8 status (RO, bit0 = OPEN)
- Config changes take effect on the next accepted tag.
- Reset mid-stream: all state returns to reset values immediately; an in-flight output tag is discarded.

Optional Feature:
- Macro: SI_TAG_GATE_TIMEOUT_EN.
- Defined:
  - While OPEN with timeout!=0, each accepted tag is first tested against the timeout: if (timestamp − open_ts) ≥ timeout (unsigned, modulo 2^TS_WIDTH), the gate closes before the tag is evaluated.
  - The tag is then handled as in CLOSED; a start tag reopens the gate in the same cycle.
  - timeout=0 disables the check.
- Undefined: registers 3/4 read 0 and ignore writes; the gate closes only on stop_ch.

Test Plan:
- enable=0, send 10 tags on ch 5 → all 10 forwarded unchanged, counters remain 0.
- enable=1, start_ch=0, stop_ch=1; send ch0@100, ch3@200, ch3@300, ch1@400, ch3@500 → output ch3@200 and ch3@300 only; pass_cnt=2, drop_cnt=1, gates_cnt=1, status=0.
- m_tready held low 5 cycles with 3 queued tags → s_tready=0 after the first is captured; output is stable; no loss or duplication after release.
- start_ch=stop_ch=2; send ch2@10, ch4@20, ch2@30, ch4@40 → only ch4@20 forwarded.
- With SI_TAG_GATE_TIMEOUT_EN, timeout=100; send ch0@1000, ch3@1099, ch3@1100 → ch3@1099 forwarded, ch3@1100 dropped (drop_cnt=1), status=0.
- Preload drop_cnt=0xFFFFFFFF (via drops), drop once more → stays 0xFFFFFFFF; write ctrl.clear → reads 0. Assert sys_clk_rst_n low mid-stream → m_tvalid=0 immediately, status=0.

Source files
------------

// File: rtl/si_tag_gate.sv
// rtl/si_tag_gate.sv - start/stop channel time gate on a tag stream with Wishbone config and counters
// Optional feature macro: SI_TAG_GATE_TIMEOUT_EN (closes an open gate once a tag arrives timeout units after it opened)

module si_tag_gate #(
  parameter int TS_WIDTH = 64,
  parameter int CH_WIDTH = 6
) (
  input  logic                sys_clk,
  input  logic                sys_clk_rst_n,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [TS_WIDTH-1:0] s_timestamp,
  input  logic [CH_WIDTH-1:0] s_channel,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [TS_WIDTH-1:0] m_timestamp,
  output logic [CH_WIDTH-1:0] m_channel,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [7:0]          wb_adr,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack
);

  localparam logic [7:0] ADR_CTRL   = 8'd0;
  localparam logic [7:0] ADR_START  = 8'd1;
  localparam logic [7:0] ADR_STOP   = 8'd2;
  localparam logic [7:0] ADR_TO_LO  = 8'd3;
  localparam logic [7:0] ADR_TO_HI  = 8'd4;
  localparam logic [7:0] ADR_PASS   = 8'd5;
  localparam logic [7:0] ADR_DROP   = 8'd6;
  localparam logic [7:0] ADR_GATES  = 8'd7;
  localparam logic [7:0] ADR_STATUS = 8'd8;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic {ST_CLOSED = 1'b0, ST_OPEN = 1'b1} gate_state_t;

  gate_state_t         state_q;
  gate_state_t         state_d;
  logic                enable_q;
  logic [CH_WIDTH-1:0] start_ch_q;
  logic [CH_WIDTH-1:0] stop_ch_q;
  logic [31:0]         pass_cnt;
  logic [31:0]         drop_cnt;
  logic [31:0]         gates_cnt;

  logic                accept;
  logic                hit_start;
  logic                hit_stop;
  logic                expired;
  logic                gate_open;
  logic                fwd;
  logic                pass_ev;
  logic                drop_ev;
  logic                gate_ev;
  logic                wb_req;
  logic                wb_wr;
  logic                clear_cnt;
  logic [31:0]         rd_data;
  logic                unused_wb_bits;

  // Single-entry output slice: take a new tag whenever the slice is empty or draining
  assign s_tready  = !m_tvalid || m_tready;
  assign accept    = s_tvalid && s_tready;
  assign hit_start = (s_channel == start_ch_q);
  assign hit_stop  = (s_channel == stop_ch_q);

  // One register access per cyc/stb assertion; the ack cycle is the handshake completion
  assign wb_req    = wb_cyc && wb_stb && !wb_ack;
  assign wb_wr     = wb_req && wb_we;
  assign clear_cnt = wb_wr && (wb_adr == ADR_CTRL) && wb_dat_i[1];

  assign unused_wb_bits = &{1'b0, wb_dat_i};

`ifdef SI_TAG_GATE_TIMEOUT_EN
  localparam int CMP_W = (TS_WIDTH > 64) ? TS_WIDTH : 64;

  logic [63:0]         timeout_q;
  logic [TS_WIDTH-1:0] open_ts_q;
  logic [TS_WIDTH-1:0] elapsed;

  // Elapsed time wraps modulo the timestamp width, so a counter rollover still measures correctly
  assign elapsed = s_timestamp - open_ts_q;
  assign expired = (state_q == ST_OPEN) && (timeout_q != 64'd0) &&
                   (CMP_W'(elapsed) >= CMP_W'(timeout_q));

  // Timeout register halves, written independently
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      timeout_q <= 64'd0;
    end else if (wb_wr && (wb_adr == ADR_TO_LO)) begin
      timeout_q[31:0] <= wb_dat_i;
    end else if (wb_wr && (wb_adr == ADR_TO_HI)) begin
      timeout_q[63:32] <= wb_dat_i;
    end
  end

  // Remember when the gate opened so later tags can be aged against it
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      open_ts_q <= '0;
    end else if (gate_ev) begin
      open_ts_q <= s_timestamp;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // An expired gate is treated as already closed when the current tag is evaluated
  assign gate_open = (state_q == ST_OPEN) && !expired;

  // Gate state register
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      state_q <= ST_CLOSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next gate state: bypass forces closed, otherwise one decision per accepted tag
  always_comb begin
    state_d = state_q;
    if (!enable_q) begin
      state_d = ST_CLOSED;
    end else if (accept) begin
      if (!gate_open) begin
        state_d = hit_start ? ST_OPEN : ST_CLOSED;
      end else if (hit_stop) begin
        state_d = ST_CLOSED;
      end
    end
  end

  // Per-tag actions: forward decision and counter events
  always_comb begin
    fwd     = 1'b0;
    pass_ev = 1'b0;
    drop_ev = 1'b0;
    gate_ev = 1'b0;
    if (accept) begin
      if (!enable_q) begin
        fwd = 1'b1;
      end else if (!gate_open) begin
        if (hit_start) begin
          gate_ev = 1'b1;
        end else begin
          drop_ev = 1'b1;
        end
      end else if (!hit_stop && !hit_start) begin
        fwd     = 1'b1;
        pass_ev = 1'b1;
      end
    end
  end

  // Output slice: load on forward, bubble on a swallowed tag, empty when the sink takes it
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      m_tvalid    <= 1'b0;
      m_timestamp <= '0;
      m_channel   <= '0;
    end else if (accept) begin
      m_tvalid <= fwd;
      if (fwd) begin
        m_timestamp <= s_timestamp;
        m_channel   <= s_channel;
      end
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Saturating event counters; a clear write overrides any same-cycle event
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      pass_cnt  <= 32'd0;
      drop_cnt  <= 32'd0;
      gates_cnt <= 32'd0;
    end else if (clear_cnt) begin
      pass_cnt  <= 32'd0;
      drop_cnt  <= 32'd0;
      gates_cnt <= 32'd0;
    end else begin
      if (pass_ev && (pass_cnt != CNT_MAX)) begin
        pass_cnt <= pass_cnt + 32'd1;
      end
      if (drop_ev && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
      if (gate_ev && (gates_cnt != CNT_MAX)) begin
        gates_cnt <= gates_cnt + 32'd1;
      end
    end
  end

  // Configuration registers; clear is a strobe and is not stored
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      enable_q   <= 1'b0;
      start_ch_q <= '0;
      stop_ch_q  <= CH_WIDTH'(1);
    end else if (wb_wr) begin
      case (wb_adr)
        ADR_CTRL:  enable_q   <= wb_dat_i[0];
        ADR_START: start_ch_q <= wb_dat_i[CH_WIDTH-1:0];
        ADR_STOP:  stop_ch_q  <= wb_dat_i[CH_WIDTH-1:0];
        default:   ;
      endcase
    end
  end

  // Register read mux; unmapped words read as zero
  always_comb begin
    rd_data = 32'd0;
    case (wb_adr)
      ADR_CTRL:   rd_data = {31'd0, enable_q};
      ADR_START:  rd_data = 32'(start_ch_q);
      ADR_STOP:   rd_data = 32'(stop_ch_q);
`ifdef SI_TAG_GATE_TIMEOUT_EN
      ADR_TO_LO:  rd_data = timeout_q[31:0];
      ADR_TO_HI:  rd_data = timeout_q[63:32];
`endif
      ADR_PASS:   rd_data = pass_cnt;
      ADR_DROP:   rd_data = drop_cnt;
      ADR_GATES:  rd_data = gates_cnt;
      ADR_STATUS: rd_data = {31'd0, state_q == ST_OPEN};
      default:    rd_data = 32'd0;
    endcase
  end

  // Wishbone ack pulse with registered read data
  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack <= wb_req;
      if (wb_req) begin
        wb_dat_o <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_si_tag_gate.sv
// tb/tb_si_tag_gate.sv - randomized and directed bench for si_tag_gate against a behavioural gate model

module tb_si_tag_gate;

  typedef struct {
    logic [63:0] ts;
    logic [5:0]  ch;
  } tag_t;

  logic        sys_clk = 1'b0;
  logic        sys_clk_rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_timestamp;
  logic [5:0]  s_channel;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_timestamp;
  logic [5:0]  m_channel;
  logic        wb_cyc, wb_stb, wb_we;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  int checks   = 0;
  int failures = 0;

  // bench-side reference model of the gate
  bit          md_en;
  logic [5:0]  md_start, md_stop;
  logic [63:0] md_to;
  bit          md_open;
  logic [63:0] md_open_ts;
  logic [31:0] md_pass, md_drop, md_gates;

  tag_t stim_q[$];
  tag_t exp_q[$];
  tag_t out_log[$];

  int          tready_mode = 0;
  bit          gaps = 0;
  bit          acc_seen = 0;
  bit          prev_hold = 0;
  logic [63:0] prev_ts;
  logic [5:0]  prev_ch;

  si_tag_gate #(.TS_WIDTH(64), .CH_WIDTH(6)) dut (
    .sys_clk(sys_clk), .sys_clk_rst_n(sys_clk_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_timestamp(s_timestamp), .s_channel(s_channel),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_timestamp(m_timestamp), .m_channel(m_channel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic tag_t mk(input logic [63:0] ts, input logic [5:0] ch);
    tag_t t;
    t.ts = ts;
    t.ch = ch;
    return t;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    md_en = 0; md_start = 6'd0; md_stop = 6'd1; md_to = 64'd0;
    md_open = 0; md_open_ts = 64'd0;
    md_pass = 32'd0; md_drop = 32'd0; md_gates = 32'd0;
  endtask

  // what the gate must do with one accepted tag
  task automatic model_tag(input logic [63:0] ts, input logic [5:0] ch);
    if (!md_en) begin
      exp_q.push_back(mk(ts, ch));
      return;
    end
`ifdef SI_TAG_GATE_TIMEOUT_EN
    if (md_open && md_to != 64'd0 && (ts - md_open_ts) >= md_to) md_open = 0;
`endif
    if (!md_open) begin
      if (ch == md_start) begin
        md_open = 1; md_open_ts = ts; md_gates = sat_inc(md_gates);
      end else begin
        md_drop = sat_inc(md_drop);
      end
    end else if (ch == md_stop) begin
      md_open = 0;
    end else if (ch != md_start) begin
      exp_q.push_back(mk(ts, ch));
      md_pass = sat_inc(md_pass);
    end
  endtask

  task automatic model_cfg(input logic [7:0] adr, input logic [31:0] d);
    case (adr)
      8'd0: begin
        md_en = d[0];
        if (d[1]) begin md_pass = 0; md_drop = 0; md_gates = 0; end
        if (!md_en) md_open = 0;
      end
      8'd1: md_start = d[5:0];
      8'd2: md_stop = d[5:0];
`ifdef SI_TAG_GATE_TIMEOUT_EN
      8'd3: md_to[31:0] = d;
      8'd4: md_to[63:32] = d;
`endif
      default: ;
    endcase
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    @(posedge sys_clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_i = d;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!wb_ack && n < 20);
    chk("wb_ack_seen", {63'd0, wb_ack}, 64'd1);
    q = wb_dat_o;
    @(posedge sys_clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(negedge sys_clk);
    chk("wb_ack_pulse", {63'd0, wb_ack}, 64'd0);
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, adr, d, q);
    model_cfg(adr, d);
  endtask

  task automatic wb_check(input logic [7:0] adr, input logic [31:0] req, input string name);
    logic [31:0] q;
    wb_xfer(1'b0, adr, 32'd0, q);
    chk(name, {32'd0, q}, {32'd0, req});
  endtask

  task automatic push(input logic [63:0] ts, input logic [5:0] ch);
    stim_q.push_back(mk(ts, ch));
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge sys_clk);
      if (stim_q.size() == 0 && !s_tvalid && exp_q.size() == 0 && !m_tvalid) done = 1;
    end
    chk("drain", {63'd0, done}, 64'd1);
  endtask

  task automatic chk_log(input int idx, input logic [63:0] ts, input logic [5:0] ch, input string name);
    if (out_log.size() > idx) begin
      chk({name, "_ts"}, out_log[idx].ts, ts);
      chk({name, "_ch"}, {58'd0, out_log[idx].ch}, {58'd0, ch});
    end
  endtask

  // input driver: pops the stimulus queue and holds each tag until accepted
  initial begin
    s_tvalid = 0; s_timestamp = 64'd0; s_channel = 6'd0;
    forever begin
      @(posedge sys_clk); #1;
      if (!sys_clk_rst_n) begin
        s_tvalid = 0;
      end else begin
        if (s_tvalid && acc_seen) s_tvalid = 0;
        if (!s_tvalid && stim_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
          tag_t t;
          t = stim_q.pop_front();
          s_timestamp = t.ts; s_channel = t.ch; s_tvalid = 1;
        end
      end
      acc_seen = 0;
    end
  end

  // output sink ready pattern
  initial begin
    m_tready = 1;
    forever begin
      @(posedge sys_clk); #1;
      case (tready_mode)
        0: m_tready = 1;
        1: m_tready = 0;
        default: m_tready = ($urandom_range(1) == 1);
      endcase
    end
  end

  // compare process: handshake rules, slice stability, output order against the model
  always @(negedge sys_clk) begin
    if (!sys_clk_rst_n) begin
      prev_hold = 0;
    end else begin
      chk("s_tready_rule", {63'd0, s_tready}, {63'd0, (!m_tvalid || m_tready)});
      if (prev_hold) begin
        chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
        chk("hold_ts", m_timestamp, prev_ts);
        chk("hold_ch", {58'd0, m_channel}, {58'd0, prev_ch});
      end
      if (m_tvalid && m_tready) begin
        chk("out_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          tag_t e;
          e = exp_q.pop_front();
          chk("out_ts", m_timestamp, e.ts);
          chk("out_ch", {58'd0, m_channel}, {58'd0, e.ch});
        end
        out_log.push_back(mk(m_timestamp, m_channel));
      end
      prev_hold = m_tvalid && !m_tready;
      prev_ts = m_timestamp;
      prev_ch = m_channel;
      if (s_tvalid && s_tready) begin
        model_tag(s_timestamp, s_channel);
        acc_seen = 1;
      end
    end
  end

  initial begin
    logic [63:0] ts_acc;
    logic [31:0] drop0;
    int n;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 8'd0; wb_dat_i = 32'd0;
    model_reset();
    sys_clk_rst_n = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_m_ts", m_timestamp, 64'd0);
    chk("rst_m_ch", {58'd0, m_channel}, 64'd0);
    chk("rst_wb_ack", {63'd0, wb_ack}, 64'd0);
    chk("rst_wb_dat", {32'd0, wb_dat_o}, 64'd0);
    sys_clk_rst_n = 1;

    wb_check(8'd0, 32'd0, "rst_ctrl");
    wb_check(8'd1, 32'd0, "rst_start");
    wb_check(8'd2, 32'd1, "rst_stop");
    wb_check(8'd5, 32'd0, "rst_pass");
    wb_check(8'd8, 32'd0, "rst_status");
    wb_write(8'd9, 32'hFFFF_FFFF);
    wb_check(8'd9, 32'd0, "unmapped_9");
    wb_check(8'd200, 32'd0, "unmapped_200");

    // bypass: everything forwarded, counters frozen
    tready_mode = 2; gaps = 1;
    for (int i = 0; i < 10; i++) push(64'd1000 + 64'(i * 7), 6'd5);
    wait_drain();
    chk("byp_count", 64'(out_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) chk_log(i, 64'd1000 + 64'(i * 7), 6'd5, "byp");
    wb_check(8'd5, 32'd0, "byp_pass");
    wb_check(8'd6, 32'd0, "byp_drop");
    wb_check(8'd7, 32'd0, "byp_gates");

    // basic start/stop gating
    out_log.delete();
    tready_mode = 0; gaps = 0;
    wb_write(8'd1, 32'd0);
    wb_write(8'd2, 32'd1);
    wb_write(8'd0, 32'd1);
    push(64'd100, 6'd0); push(64'd200, 6'd3); push(64'd300, 6'd3);
    push(64'd400, 6'd1); push(64'd500, 6'd3);
    wait_drain();
    chk("gate_count", 64'(out_log.size()), 64'd2);
    chk_log(0, 64'd200, 6'd3, "gate0");
    chk_log(1, 64'd300, 6'd3, "gate1");
    wb_check(8'd5, 32'd2, "gate_pass");
    wb_check(8'd6, 32'd1, "gate_drop");
    wb_check(8'd7, 32'd1, "gate_gates");
    wb_check(8'd8, 32'd0, "gate_status");

    // backpressure with queued tags
    out_log.delete();
    tready_mode = 1;
    push(64'd600, 6'd0); push(64'd610, 6'd3); push(64'd620, 6'd3); push(64'd630, 6'd3);
    n = 0;
    while (!m_tvalid && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("bp_capture", {63'd0, m_tvalid}, 64'd1);
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("bp_s_tready", {63'd0, s_tready}, 64'd0);
      chk("bp_m_ts", m_timestamp, 64'd610);
    end
    tready_mode = 0;
    wait_drain();
    chk("bp_count", 64'(out_log.size()), 64'd3);
    chk_log(0, 64'd610, 6'd3, "bp0");
    chk_log(1, 64'd620, 6'd3, "bp1");
    chk_log(2, 64'd630, 6'd3, "bp2");
    push(64'd640, 6'd1);
    wait_drain();

    // start == stop toggles the gate
    out_log.delete();
    wb_write(8'd1, 32'd2);
    wb_write(8'd2, 32'd2);
    push(64'd10, 6'd2); push(64'd20, 6'd4); push(64'd30, 6'd2); push(64'd40, 6'd4);
    wait_drain();
    chk("tog_count", 64'(out_log.size()), 64'd1);
    chk_log(0, 64'd20, 6'd4, "tog0");
    wb_check(8'd8, 32'd0, "tog_status");

    // timeout
    wb_write(8'd1, 32'd0);
    wb_write(8'd2, 32'd1);
`ifdef SI_TAG_GATE_TIMEOUT_EN
    out_log.delete();
    wb_write(8'd3, 32'd100);
    wb_write(8'd4, 32'd0);
    wb_check(8'd3, 32'd100, "to_reg_lo");
    drop0 = md_drop;
    push(64'd1000, 6'd0); push(64'd1099, 6'd3); push(64'd1100, 6'd3);
    wait_drain();
    chk("to_count", 64'(out_log.size()), 64'd1);
    chk_log(0, 64'd1099, 6'd3, "to0");
    wb_check(8'd6, drop0 + 32'd1, "to_drop");
    wb_check(8'd8, 32'd0, "to_status");
    wb_write(8'd3, 32'd0);
`else
    wb_write(8'd3, 32'd55);
    wb_write(8'd4, 32'd77);
    wb_check(8'd3, 32'd0, "to_off_lo");
    wb_check(8'd4, 32'd0, "to_off_hi");
`endif

    // randomized traffic with periodic reconfiguration
    ts_acc = 64'd5000;
    for (int b = 0; b < 6; b++) begin
      wb_write(8'd0, {31'd0, ($urandom_range(4) != 0)});
      wb_write(8'd1, $urandom_range(3));
      wb_write(8'd2, $urandom_range(3));
`ifdef SI_TAG_GATE_TIMEOUT_EN
      wb_write(8'd3, ($urandom_range(2) == 0) ? 32'd0 : $urandom_range(60, 1));
`endif
      tready_mode = 2; gaps = 1;
      for (int i = 0; i < 50; i++) begin
        ts_acc = ts_acc + 64'($urandom_range(20, 1));
        push(ts_acc, 6'($urandom_range(4)));
      end
      wait_drain();
      wb_check(8'd5, md_pass, "rnd_pass");
      wb_check(8'd6, md_drop, "rnd_drop");
      wb_check(8'd7, md_gates, "rnd_gates");
      wb_check(8'd8, {31'd0, md_open}, "rnd_status");
    end
    tready_mode = 0; gaps = 0;
`ifdef SI_TAG_GATE_TIMEOUT_EN
    wb_write(8'd3, 32'd0);
`endif

    // saturation and clear
    wb_write(8'd0, 32'd0);
    wb_write(8'd1, 32'd0);
    wb_write(8'd2, 32'd1);
    wb_write(8'd0, 32'd1);
    @(negedge sys_clk);
    force dut.drop_cnt = 32'hFFFF_FFFE;
    @(negedge sys_clk);
    release dut.drop_cnt;
    md_drop = 32'hFFFF_FFFE;
    push(64'd1, 6'd3); push(64'd2, 6'd3);
    wait_drain();
    wb_check(8'd6, 32'hFFFF_FFFF, "sat_drop_max");
    push(64'd3, 6'd3);
    wait_drain();
    wb_check(8'd6, 32'hFFFF_FFFF, "sat_drop_hold");
    wb_write(8'd0, 32'd3);
    wb_check(8'd6, 32'd0, "clr_drop");
    wb_check(8'd5, 32'd0, "clr_pass");
    wb_check(8'd7, 32'd0, "clr_gates");
    wb_check(8'd0, 32'd1, "clr_ctrl_selfclear");

    // reset in the middle of a stalled stream
    wb_write(8'd0, 32'd0);
    tready_mode = 1;
    push(64'd700, 6'd5); push(64'd710, 6'd5); push(64'd720, 6'd5);
    n = 0;
    while (!m_tvalid && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("mid_capture", {63'd0, m_tvalid}, 64'd1);
    @(negedge sys_clk);
    #2 sys_clk_rst_n = 0;
    #1;
    chk("mid_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("mid_rst_m_ts", m_timestamp, 64'd0);
    stim_q.delete();
    exp_q.delete();
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_clk_rst_n = 1;
    tready_mode = 0;
    repeat (3) @(negedge sys_clk);
    chk("mid_after_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    wb_check(8'd8, 32'd0, "mid_status");
    wb_check(8'd0, 32'd0, "mid_ctrl");
    wb_check(8'd2, 32'd1, "mid_stop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
